// File: rtl/systolic_row_loader.sv
`default_nettype none
// =====================================================================
// Module  : systolic_row_loader
// Brief   : Streams N-element operand rows from a synchronous single-port
//           memory into a systolic array input stage (valid/ready).
// Revision: 1.0 - initial release
// =====================================================================
module systolic_row_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int N      = 4,
    parameter int ROW_W  = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   row_stride,
    input  logic [ROW_W-1:0]    num_rows,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_wren,
    input  logic [DATA_W-1:0]   mem_q,
    output logic [N*DATA_W-1:0] row_data,
    output logic                row_valid,
    input  logic                row_ready,
    output logic                row_last,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_fetch  = 2'd1;
    localparam logic [1:0] c_fill   = 2'd2;
    localparam logic [1:0] c_finish = 2'd3;

    // A single-element row is fully issued on its launch edge.
    localparam logic [1:0]       c_row_state = (N > 1) ? c_fetch : c_fill;
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] c_full      = CNT_W'(N);

    logic [1:0]          r_state;
    logic [1:0]          w_next;

    logic [ADDR_W-1:0]   r_mem_address;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_stride;
    logic [ROW_W-1:0]    r_rows_left;
    logic [IDX_W-1:0]    r_issue_idx;
    logic                r_p1_valid;
    logic [IDX_W-1:0]    r_p1_idx;
    logic                r_p2_valid;
    logic [IDX_W-1:0]    r_p2_idx;
    logic [N*DATA_W-1:0] r_asm;
    logic [CNT_W-1:0]    r_asm_cnt;
    logic [N*DATA_W-1:0] r_row_data;
    logic                r_row_valid;
    logic                r_row_last;
    logic                r_busy;

    logic                w_accept;
    logic                w_xfer;
    logic                w_more;
    logic                w_next_row;
    logic                w_last_hs;

    assign w_accept   = (r_state == c_idle) && start;
    assign w_xfer     = (r_asm_cnt == c_full) && (!r_row_valid || row_ready);
    assign w_more     = (r_rows_left != '0);
    assign w_next_row = w_xfer && w_more;
    assign w_last_hs  = r_row_valid && row_ready && r_row_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_next = (num_rows == '0) ? c_finish : c_row_state;
                end
            end
            c_fetch: begin
                if (r_issue_idx == c_last_idx) begin
                    w_next = c_fill;
                end
            end
            c_fill: begin
                if (w_last_hs) begin
                    w_next = c_finish;
                end else if (w_next_row) begin
                    w_next = c_row_state;
                end
            end
            c_finish: begin
                // busy still set here only on the zero-row path
                if (!r_busy) begin
                    w_next = c_idle;
                end
            end
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        busy     = r_busy;
        done     = (r_state == c_finish) && !r_busy;
        mem_wren = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_address <= '0;
            r_row_base    <= '0;
            r_stride      <= '0;
            r_rows_left   <= '0;
            r_issue_idx   <= '0;
            r_p1_valid    <= 1'b0;
            r_p1_idx      <= '0;
            r_p2_valid    <= 1'b0;
            r_p2_idx      <= '0;
            r_asm         <= '0;
            r_asm_cnt     <= '0;
            r_row_data    <= '0;
            r_row_valid   <= 1'b0;
            r_row_last    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_p1_valid <= 1'b0;
            r_p2_valid <= r_p1_valid;
            r_p2_idx   <= r_p1_idx;

            if (w_accept) begin
                r_busy      <= 1'b1;
                r_stride    <= row_stride;
                r_rows_left <= num_rows - ROW_W'(1);
                r_row_base  <= base_addr;
                if (num_rows != '0) begin
                    r_mem_address <= base_addr;
                    r_p1_valid    <= 1'b1;
                    r_p1_idx      <= '0;
                    r_issue_idx   <= IDX_W'(1);
                end
            end else if (w_next_row) begin
                r_row_base    <= r_row_base + r_stride;
                r_mem_address <= r_row_base + r_stride;
                r_p1_valid    <= 1'b1;
                r_p1_idx      <= '0;
                r_issue_idx   <= IDX_W'(1);
                r_rows_left   <= r_rows_left - ROW_W'(1);
            end else if (r_state == c_fetch) begin
                r_mem_address <= r_row_base + ADDR_W'(r_issue_idx);
                r_p1_valid    <= 1'b1;
                r_p1_idx      <= r_issue_idx;
                r_issue_idx   <= r_issue_idx + IDX_W'(1);
            end

            if (w_last_hs || (r_state == c_finish)) begin
                r_busy <= 1'b0;
            end

            if (w_xfer) begin
                r_asm_cnt <= '0;
            end else if (r_p2_valid) begin
                r_asm[r_p2_idx*DATA_W +: DATA_W] <= mem_q;
                r_asm_cnt <= r_asm_cnt + CNT_W'(1);
            end

            if (w_xfer) begin
                r_row_valid <= 1'b1;
                r_row_data  <= r_asm;
                r_row_last  <= !w_more;
            end else if (row_ready) begin
                r_row_valid <= 1'b0;
                r_row_last  <= 1'b0;
            end
        end
    end

    assign mem_address = r_mem_address;
    assign row_data    = r_row_data;
    assign row_valid   = r_row_valid;
    assign row_last    = r_row_last;

endmodule
`default_nettype wire

// File: tb/tb_systolic_row_loader.sv
`default_nettype none
// =====================================================================
// Module  : tb_systolic_row_loader
// Brief   : Directed self-checking bench with a row-level reference model.
// Revision: 1.0 - initial release
// =====================================================================
module tb_systolic_row_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int N      = 4;
    localparam int ROW_W  = 8;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   row_stride;
    logic [ROW_W-1:0]    num_rows;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_wren;
    logic [DATA_W-1:0]   mem_q;
    logic [N*DATA_W-1:0] row_data;
    logic                row_valid;
    logic                row_ready;
    logic                row_last;
    logic                busy;
    logic                done;

    systolic_row_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N(N), .ROW_W(ROW_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .row_stride(row_stride), .num_rows(num_rows),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_q(mem_q),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_last(row_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) mem_q <= mem[mem_address];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected rows: {last, packed data}
    logic [64:0] exp_q [$];
    int rises [$];
    int n_done, done_cyc, n_busy, n_valid, n_rows, s_cyc;
    bit prev_v;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [11:0] b, input logic [11:0] s, input int rows);
        logic [63:0] d;
        logic [11:0] a;
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < N; j++) begin
                a = b + 12'(r) * s + 12'(j);
                d[j*16 +: 16] = mem[a];
            end
            exp_q.push_back({(r == rows - 1), d});
        end
    endtask

    task automatic start_op(input logic [11:0] b, input logic [11:0] s, input logic [7:0] n,
                            input logic rdy);
        @(posedge clock); #1;
        base_addr = b; row_stride = s; num_rows = n; row_ready = rdy; start = 1'b1;
        n_done = 0; done_cyc = 0; n_busy = 0; n_valid = 0; n_rows = 0; prev_v = 0;
        rises.delete();
        @(posedge clock); #1;
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (n_done == 0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        if (n_done == 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, required a pulse", limit);
        end
        repeat (4) @(negedge clock);
    endtask

    function automatic logic [79:0] first_lat();
        return (rises.size() > 0) ? 80'(rises[0] - s_cyc) : 80'hFFFF;
    endfunction

    function automatic logic [79:0] period();
        return (rises.size() > 1) ? 80'(rises[1] - rises[0]) : 80'hFFFF;
    endfunction

    task automatic run_t1(input string p, input bit poke);
        push_expected(12'h000, 12'h004, 4);
        check({p, "_pin_row0"}, 80'(exp_q[0][63:0]), 80'h0024_0019_000E_0003);
        check({p, "_pin_row3"}, 80'(exp_q[3]), {15'd0, 1'b1, 64'h00A8_009D_0092_0087});
        start_op(12'h000, 12'h004, 8'd4, 1'b1);
        if (poke) begin
            repeat (2) @(posedge clock); #1;
            base_addr = 12'h100; num_rows = 8'd1; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        wait_done(300);
        check({p, "_first_valid"}, first_lat(), 80'd6);
        check({p, "_period"}, period(), 80'd6);
        check({p, "_done_lat"}, 80'(done_cyc - s_cyc), 80'd25);
        check({p, "_done_width"}, 80'(n_done), 80'd1);
        check({p, "_busy_cycles"}, 80'(n_busy), 80'd25);
        check({p, "_rows"}, 80'(n_rows), 80'd4);
        check({p, "_queue_empty"}, 80'(exp_q.size()), 80'd0);
    endtask

    // Row-level compare process: handshakes, hold stability, pulse bookkeeping.
    initial begin
        logic [64:0] e;
        bit          hold_v;
        logic [63:0] hold_d;
        logic        hold_l;
        hold_v = 0; hold_d = '0; hold_l = 0;
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1) begin
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    check("hold_stable", 80'({row_valid, row_last, row_data}),
                          80'({1'b1, hold_l, hold_d}));
                end
                if (row_valid && !prev_v) rises.push_back(cyc);
                prev_v = row_valid;
                if (row_valid) n_valid++;
                if (busy) n_busy++;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (row_valid && row_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL row_extra: got row %0h, required none", row_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("row_data", 80'(row_data), 80'(e[63:0]));
                        check("row_last", 80'(row_last), 80'(e[64]));
                        check("mem_wren", 80'(mem_wren), 80'd0);
                        n_rows++;
                    end
                end
                hold_v = row_valid && !row_ready;
                hold_d = row_data;
                hold_l = row_last;
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] save0, save1;
        int k;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 11 + 3);
        reset_n = 1'b0; start = 1'b0; base_addr = '0; row_stride = '0;
        num_rows = '0; row_ready = 1'b1;
        n_done = 0; done_cyc = 0; n_busy = 0; n_valid = 0; n_rows = 0; s_cyc = 0; prev_v = 0;
        repeat (3) @(negedge clock);
        check("rst_mem_address", 80'(mem_address), 80'd0);
        check("rst_mem_wren", 80'(mem_wren), 80'd0);
        check("rst_row_data", 80'(row_data), 80'd0);
        check("rst_row_valid", 80'(row_valid), 80'd0);
        check("rst_row_last", 80'(row_last), 80'd0);
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_done", 80'(done), 80'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // Four contiguous rows, consumer always ready
        run_t1("t1", 1'b0);

        // Stride 8, two rows
        push_expected(12'h000, 12'h008, 2);
        check("t2_pin_row1", 80'(exp_q[1]), {15'd0, 1'b1, 64'h007C_0071_0066_005B});
        start_op(12'h000, 12'h008, 8'd2, 1'b1);
        wait_done(200);
        check("t2_first_valid", first_lat(), 80'd6);
        check("t2_done_lat", 80'(done_cyc - s_cyc), 80'd13);
        check("t2_rows", 80'(n_rows), 80'd2);

        // Back-pressure: consumer stalls after the first row appears
        push_expected(12'h000, 12'h004, 4);
        start_op(12'h000, 12'h004, 8'd4, 1'b0);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!row_valid && k < 50);
        check("t3_first_valid", 80'(cyc - s_cyc), 80'd6);
        repeat (6) @(negedge clock);
        check("t3_addr_frozen_a", 80'(mem_address), 80'h007);
        repeat (6) @(negedge clock);
        check("t3_addr_frozen_b", 80'(mem_address), 80'h007);
        check("t3_still_valid", 80'(row_valid), 80'd1);
        @(posedge clock); #1 row_ready = 1'b1;
        wait_done(300);
        check("t3_done_lat", 80'(done_cyc - s_cyc), 80'd33);
        check("t3_rows", 80'(n_rows), 80'd4);
        check("t3_queue_empty", 80'(exp_q.size()), 80'd0);

        // Address wrap across the top of memory
        save0 = mem[0]; save1 = mem[1];
        mem[12'hFFE] = 16'd5; mem[12'hFFF] = 16'd6; mem[0] = 16'd7; mem[1] = 16'd8;
        push_expected(12'hFFE, 12'h004, 1);
        check("t4_pin_row0", 80'(exp_q[0]), {15'd0, 1'b1, 64'h0008_0007_0006_0005});
        start_op(12'hFFE, 12'h004, 8'd1, 1'b1);
        wait_done(100);
        check("t4_done_lat", 80'(done_cyc - s_cyc), 80'd7);
        check("t4_rows", 80'(n_rows), 80'd1);
        mem[0] = save0; mem[1] = save1;

        // Zero rows: only a done pulse
        start_op(12'h123, 12'h001, 8'd0, 1'b1);
        wait_done(50);
        check("t5_done_lat", 80'(done_cyc - s_cyc), 80'd1);
        check("t5_done_width", 80'(n_done), 80'd1);
        check("t5_busy_cycles", 80'(n_busy), 80'd1);
        check("t5_no_valid", 80'(n_valid), 80'd0);
        check("t5_addr_kept", 80'(mem_address), 80'h001);

        // Start pulsed while busy is ignored
        run_t1("t5b", 1'b1);

        // Asynchronous reset in the middle of row 1
        push_expected(12'h000, 12'h004, 4);
        start_op(12'h000, 12'h004, 8'd4, 1'b1);
        k = 0;
        while (cyc < s_cyc + 8 && k < 50) begin
            @(negedge clock);
            k++;
        end
        #2 reset_n = 1'b0;
        #1;
        check("t6_mem_address", 80'(mem_address), 80'd0);
        check("t6_row_data", 80'(row_data), 80'd0);
        check("t6_row_valid", 80'(row_valid), 80'd0);
        check("t6_row_last", 80'(row_last), 80'd0);
        check("t6_busy", 80'(busy), 80'd0);
        check("t6_done", 80'(done), 80'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        run_t1("t6r", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
